csel_subtractor_pipe: RTL
=========================

Name: csel_subtractor_pipe

Overview:
- Two-stage pipelined 32-bit subtractor computing Diff = A - B - Bin.
- Uses carry-select internally: stage 1 resolves the low half and precomputes both variants of the high half; stage 2 selects the high half and produces flags.
- Companion to the combinational carry-select adders; feeds datapaths that need subtract/compare at full clock rate, with valid/ready flow control on both sides.

Parameters:
- WIDTH, 32, operand width; must be even and >= 8.
- LO_W, WIDTH/2, width of the low segment resolved in stage 1; 1 <= LO_W < WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts operands this cycle
- A  input  WIDTH  minuend
- B  input  WIDTH  subtrahend
- Bin  input  1  borrow in (1 = subtract one extra)
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts result
- Diff  output  WIDTH  A - B - Bin, modulo 2^WIDTH
- Bout  output  1  borrow out: 1 iff unsigned A < B + Bin
- Zero  output  1  Diff == 0
- Neg  output  1  Diff[WIDTH-1]
- Ovf  output  1  signed overflow: A[MSB] != B[MSB] and Diff[MSB] != A[MSB]

Behaviour:
- Arithmetic: computed as A + ~B + ~Bin. Carry out of the full sum = ~Bout.
- Stage 1, on accept (in_valid & in_ready):
  - Registers the low LO_W bits of the difference and carry c_lo out of the low segment.
  - Registers both high-segment sums and carries: carry-in 0 (hi0, c0) and carry-in 1 (hi1, c1).
  - Registers A[MSB] and B[MSB].
  - Sets s1_valid.
- Stage 2, when stage 1 advances:
  - Selects hi = c_lo ? hi1 : hi0 and carry = c_lo ? c1 : c0.
  - Registers Diff = {hi, lo}, Bout = ~carry, and the flags derived from the registered Diff.
  - Sets out_valid.
- Latency: exactly 2 cycles from accept to out_valid with no backpressure. Throughput is 1 beat per cycle.
- Handshake:
  - s2_adv = ~out_valid | out_ready
  - in_ready = ~s1_valid | s2_adv (combinational; no combinational path from in_valid to in_ready)
  - Stage 1 moves into stage 2 when s1_valid & s2_adv.
  - s1_valid clears when stage 1 advances without a new accept.
  - out_valid clears when out_ready is high and stage 1 is empty.
- Backpressure: while out_valid & ~out_ready, Diff, Bout, Zero, Neg and Ovf hold stable. Stage 1 holds one more beat, then in_ready deasserts. No beat is dropped or duplicated.
- Simultaneous events: in the same cycle, output consumed + stage 1 advancing + new accept all complete, keeping full throughput.
- in_valid while in_ready = 0: inputs are ignored; the source must hold them.
- Reset (asynchronous, any time including mid-operation):
  - s1_valid = 0, out_valid = 0.
  - Diff = 0, Bout = 0, Zero = 0, Neg = 0, Ovf = 0.
  - in_ready = 1 on the first cycle after release.
  - In-flight beats are discarded.
- Wrap-around: results are modulo 2^WIDTH. 0 - 1 gives all ones with Bout = 1.
- Internal segment adds may be ripple or instantiated adders; results must be bit-exact to the above.

Test Plan:
- A=0x0000_0005, B=0x0000_0003, Bin=0, out_ready=1 -> 2 cycles later: Diff=0x0000_0002, Bout=0, Zero=0, Neg=0, Ovf=0.
- A=0, B=1, Bin=0 -> Diff=0xFFFF_FFFF, Bout=1, Neg=1, Ovf=0. Then A=0x1234_0000, B=0x1233_FFFF, Bin=1 -> Diff=0, Zero=1, Bout=0 (exercises low-to-high borrow select).
- A=0x8000_0000, B=1 -> Diff=0x7FFF_FFFF, Ovf=1, Neg=0, Bout=0. A=0x7FFF_FFFF, B=0xFFFF_FFFF -> Diff=0x8000_0000, Ovf=1, Bout=1.
- Stream 8 back-to-back beats with out_ready=1 -> 8 consecutive out_valid cycles, in order, matching a reference model.
- Hold out_ready=0 for 5 cycles while streaming -> in_ready drops after 2 accepts and Diff stays stable. Release out_ready -> all beats delivered in order, none lost.
- Assert rst mid-stream with both stages full -> out_valid=0 and Diff=0 immediately. After release, in_ready=1 and the first new beat appears 2 cycles after accept.

Source files
------------

// File: rtl/csel_subtractor_pipe.sv
// Two-stage pipelined carry-select subtractor: Diff = A - B - Bin.
// Stage 1 resolves the low segment and precomputes both high-segment
// candidates. Stage 2 picks one using the low-segment carry and registers
// the result with its flags. Valid/ready flow control is on both sides.
`timescale 1ns/1ps

module csel_subtractor_pipe #(
    parameter int WIDTH = 32,
    parameter int LO_W  = WIDTH / 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Zero,
    output logic             Neg,
    output logic             Ovf
);

    localparam int HI_W = WIDTH - LO_W;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic r_s1_valid;
    logic r_out_valid;
    logic w_s2_adv;
    logic w_s1_adv;
    logic w_accept;

    // Output stage can take a new beat when empty or being drained.
    assign w_s2_adv = ~r_out_valid | out_ready;
    // in_ready depends only on registered state and out_ready, never on in_valid.
    assign in_ready = ~r_s1_valid | w_s2_adv;
    assign w_accept = in_valid & in_ready;
    assign w_s1_adv = r_s1_valid & w_s2_adv;

    // ------------------------------------------------------------------
    // Stage 1 arithmetic: A + ~B + ~Bin, split into two segments
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_nb;
    logic [LO_W:0]    w_lo_sum;
    logic [HI_W:0]    w_hi0_sum;
    logic [HI_W:0]    w_hi1_sum;

    assign w_nb = ~B;

    // Low segment takes the real carry-in (~Bin).
    assign w_lo_sum  = {1'b0, A[LO_W-1:0]} + {1'b0, w_nb[LO_W-1:0]}
                     + {{LO_W{1'b0}}, ~Bin};
    // High segment precomputed for both possible carries out of the low segment.
    assign w_hi0_sum = {1'b0, A[WIDTH-1:LO_W]} + {1'b0, w_nb[WIDTH-1:LO_W]};
    assign w_hi1_sum = {1'b0, A[WIDTH-1:LO_W]} + {1'b0, w_nb[WIDTH-1:LO_W]}
                     + {{HI_W{1'b0}}, 1'b1};

    logic [LO_W-1:0] r_lo;
    logic            r_c_lo;
    logic [HI_W-1:0] r_hi0;
    logic [HI_W-1:0] r_hi1;
    logic            r_c0;
    logic            r_c1;
    logic            r_a_msb;
    logic            r_b_msb;

    // Stage 1 valid: set on accept, cleared when it drains with no new accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 1 data: capture low result and both high candidates on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lo    <= '0;
            r_c_lo  <= 1'b0;
            r_hi0   <= '0;
            r_hi1   <= '0;
            r_c0    <= 1'b0;
            r_c1    <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
        end else if (w_accept) begin
            r_lo    <= w_lo_sum[LO_W-1:0];
            r_c_lo  <= w_lo_sum[LO_W];
            r_hi0   <= w_hi0_sum[HI_W-1:0];
            r_c0    <= w_hi0_sum[HI_W];
            r_hi1   <= w_hi1_sum[HI_W-1:0];
            r_c1    <= w_hi1_sum[HI_W];
            r_a_msb <= A[WIDTH-1];
            r_b_msb <= B[WIDTH-1];
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: carry select and flag generation
    // ------------------------------------------------------------------
    logic [HI_W-1:0]  w_hi;
    logic             w_carry;
    logic [WIDTH-1:0] w_diff;
    logic             w_ovf;

    assign w_hi    = r_c_lo ? r_hi1 : r_hi0;
    assign w_carry = r_c_lo ? r_c1  : r_c0;
    assign w_diff  = {w_hi, r_lo};
    // Signed overflow: operands of opposite sign and result sign differs from A.
    assign w_ovf   = (r_a_msb != r_b_msb) && (w_diff[WIDTH-1] != r_a_msb);

    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_zero;
    logic             r_neg;
    logic             r_ovf;

    // Output valid: set when stage 1 moves in, cleared once consumed with nothing behind it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
        end else if (w_s1_adv) begin
            r_out_valid <= 1'b1;
        end else if (w_s2_adv) begin
            r_out_valid <= 1'b0;
        end
    end

    // Output data: only updates when stage 1 advances, so it holds under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_diff <= '0;
            r_bout <= 1'b0;
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_s1_adv) begin
            r_diff <= w_diff;
            r_bout <= ~w_carry;
            r_zero <= (w_diff == '0);
            r_neg  <= w_diff[WIDTH-1];
            r_ovf  <= w_ovf;
        end
    end

    assign out_valid = r_out_valid;
    assign Diff      = r_diff;
    assign Bout      = r_bout;
    assign Zero      = r_zero;
    assign Neg       = r_neg;
    assign Ovf       = r_ovf;

endmodule
